calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Control FSM for the calculator datapath. Turns operator keypresses (enter, clear, operation code) into a timed sequence of 3-bit `sel` commands that drive the operand holders and the ALU: capture A, latch operation, capture B, execute, show, clear. Sits between the key/switch inputs and the holder/ALU blocks. Each capture command is held for a fixed window so the holders' two-sample stability check can complete.

## Interface
- `LOAD_CYCLES`, 4: cycles a capture command (`SEL_LOAD_A`/`SEL_LOAD_B`/`SEL_CHAIN_A`) is held; minimum 2.
- `EXEC_CYCLES`, 2: cycles `SEL_EXEC` is held; minimum 1.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `key_enter`  in  1  raw enter button level, asynchronous to `clock`.
- `key_clear`  in  1  raw clear button level, asynchronous to `clock`.
- `op_in`  in  2  operation switches; sampled on the enter press that leaves `WAIT_OP`.
- `sel`  out  3  command to holders/ALU.
- `op`  out  2  latched operation code for the ALU.
- `busy`  out  1  high while a timed command (capture, exec, clear) is in progress.
- `result_valid`  out  1  high while in `SHOW`.

## Operation
- Sel codes: `SEL_IDLE`=000, `SEL_LOAD_A`=001, `SEL_LOAD_B`=010, `SEL_EXEC`=011, `SEL_CLEAR`=100, `SEL_CHAIN_A`=101, `SEL_SHOW`=110.
- Each key passes through a 2-flop synchronizer and a rising-edge detector. The result is a one-cycle pulse: `enter_p` or `clear_p`.
- States and `sel` per state:
  - `IDLE`: `sel`=`SEL_IDLE`.
  - `LOAD_A`: `sel`=`SEL_LOAD_A`.
  - `WAIT_OP`: `sel`=`SEL_IDLE`.
  - `LOAD_B`: `sel`=`SEL_LOAD_B`.
  - `WAIT_EXEC`: `sel`=`SEL_IDLE`.
  - `EXEC`: `sel`=`SEL_EXEC`.
  - `SHOW`: `sel`=`SEL_SHOW`.
  - `CLEAR`: `sel`=`SEL_CLEAR`.
  - `CHAIN`: `sel`=`SEL_CHAIN_A`.
- Transitions:
  - `IDLE` -> `LOAD_A` on `enter_p`.
  - `LOAD_A` -> `WAIT_OP` after `LOAD_CYCLES`.
  - `WAIT_OP` -> `LOAD_B` on `enter_p`; `op` <= `op_in` on that same edge.
  - `LOAD_B` -> `WAIT_EXEC` after `LOAD_CYCLES`.
  - `WAIT_EXEC` -> `EXEC` on `enter_p`.
  - `EXEC` -> `SHOW` after `EXEC_CYCLES`.
  - `SHOW` -> see Configuration.
  - `CLEAR` -> `IDLE` after 1 cycle.
  - `CHAIN` -> `WAIT_OP` after `LOAD_CYCLES`.
- `clear_p` has priority over everything. From any state it forces `CLEAR` on the next edge, including mid-countdown; the counter is reset.
- `clear_p` and `enter_p` in the same cycle: clear wins and the enter is discarded.
- `enter_p` during a timed state (`LOAD_*`, `EXEC`, `CLEAR`, `CHAIN`) is ignored. It is not queued.
- `op` holds its value until the next `WAIT_OP` exit. `CLEAR` resets `op` to 00.
- `busy` = state in {`LOAD_A`, `LOAD_B`, `EXEC`, `CLEAR`, `CHAIN`}.
- Dwell counter:
  - Width `$clog2(max(LOAD_CYCLES, EXEC_CYCLES)+1)`.
  - Loaded with N-1 on state entry; decremented each cycle.
  - State exits on the edge where the counter = 0.
  - A state of length N therefore presents its `sel` for exactly N cycles.

## Timing
- Reset (async assert, release sampled on `clock`) gives: state `IDLE`, `sel`=000, `op`=00, `busy`=0, `result_valid`=0, synchronizers and edge detectors 0, counter 0.
- Outputs are registered; `sel` changes in the same cycle as the state.
- Key latency: a rising key level sampled on clock edge k gives a pulse high in cycle k+2 and a state change at edge k+3.
- A held key produces exactly one pulse. A new press requires the key to go low for at least one sampled cycle.
- Full A -> op -> B -> result pass: 3 presses plus `2*LOAD_CYCLES + EXEC_CYCLES` busy cycles.

## Configuration
- `CALC_CHAIN_EN` defined:
  - `enter_p` in `SHOW` -> `CHAIN`, which presents `SEL_CHAIN_A` for `LOAD_CYCLES` so the result is reloaded as operand A.
  - `CHAIN` then goes to `WAIT_OP`.
- `CALC_CHAIN_EN` undefined:
  - `enter_p` in `SHOW` -> `CLEAR` -> `IDLE`.
  - Code 101 is never emitted and the `CHAIN` state is not built.

## Structure
- Package `calc_pkg` holds:
  - the state enum `calc_state_t`;
  - the seven `SEL_*` constants (shared with the holder and ALU blocks);
  - `op` encoding constants.
- One sub-module: `key_pulse`. It contains the 2-flop synchronizer plus rising-edge detector, with ports `clock`, `reset_n`, `key`, `pulse`, and is instantiated twice.

## Test plan
- Reset, then one full sequence: enter, then `op_in`=10 + enter, then enter. Expect `sel` 001 for 4 cycles, 010 for 4 cycles, 011 for 2 cycles, then 110 with `result_valid`=1 and `op`=10.
- Hold `key_enter` high for 50 cycles in `IDLE`: exactly one `LOAD_A` entry, and the state is `WAIT_OP` after cycle 4 of `LOAD_A`.
- Assert `key_clear` during cycle 2 of `LOAD_B`: `sel`=100 for one cycle, then `IDLE`, with `op`=00 and `busy`=0.
- Simultaneous enter and clear rising edges in `WAIT_EXEC`: `CLEAR` is taken and `EXEC` is never entered.
- Assert `reset_n` low asynchronously mid-`EXEC`: outputs go to their reset values before the next clock edge.
- With `CALC_CHAIN_EN`, enter in `SHOW`: `sel`=101 for 4 cycles, then `WAIT_OP`. Without it: `sel`=100 for 1 cycle, then `IDLE`.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator control path.
// Optional feature: CALC_CHAIN_EN adds the CHAIN state (result reloaded as operand A).
// Contents: calc_state_t state enum, SEL_* command codes (also used by the holder and
// ALU blocks), op encodings, and sel/busy decode helpers.
package calc_pkg;

    // Sequencer states; CHAIN only exists when chaining is built in.
    typedef enum logic [3:0] {
        IDLE,
        LOAD_A,
        WAIT_OP,
        LOAD_B,
        WAIT_EXEC,
        EXEC,
        SHOW,
        CLEAR
`ifdef CALC_CHAIN_EN
        ,
        CHAIN
`endif
    } calc_state_t;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned OP_W  = 2;

    // Commands to the operand holders and ALU.
    localparam logic [SEL_W-1:0] SEL_IDLE    = 3'b000;
    localparam logic [SEL_W-1:0] SEL_LOAD_A  = 3'b001;
    localparam logic [SEL_W-1:0] SEL_LOAD_B  = 3'b010;
    localparam logic [SEL_W-1:0] SEL_EXEC    = 3'b011;
    localparam logic [SEL_W-1:0] SEL_CLEAR   = 3'b100;
    localparam logic [SEL_W-1:0] SEL_CHAIN_A = 3'b101;
    localparam logic [SEL_W-1:0] SEL_SHOW    = 3'b110;

    // Operation codes carried on op; 00 is also the cleared value.
    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_AND = 2'b10;
    localparam logic [OP_W-1:0] OP_OR  = 2'b11;

    // Command presented while in a given state.
    function automatic logic [SEL_W-1:0] sel_of(input calc_state_t s);
        logic [SEL_W-1:0] r;
        r = SEL_IDLE;
        case (s)
            LOAD_A: r = SEL_LOAD_A;
            LOAD_B: r = SEL_LOAD_B;
            EXEC:   r = SEL_EXEC;
            SHOW:   r = SEL_SHOW;
            CLEAR:  r = SEL_CLEAR;
`ifdef CALC_CHAIN_EN
            CHAIN:  r = SEL_CHAIN_A;
`endif
            default: r = SEL_IDLE;
        endcase
        return r;
    endfunction

    // Timed states, during which enter is ignored.
    function automatic logic busy_of(input calc_state_t s);
        logic r;
        r = 1'b0;
        case (s)
            LOAD_A, LOAD_B, EXEC, CLEAR: r = 1'b1;
`ifdef CALC_CHAIN_EN
            CHAIN: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_pulse.sv
// Key conditioner: 2-flop synchronizer, then registered rising-edge detector.
// Ports: clock, reset_n (async active-low), key (raw async level),
//        pulse (one-cycle high per press, high in cycle k+2 for a rise sampled at edge k).
module key_pulse (
    input  logic clock,
    input  logic reset_n,
    input  logic key,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    // prev holds the last synchronized level so a held key yields one pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            prev  <= sync2;
            pulse <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: turns enter/clear presses and op switches into timed sel commands.
// Optional feature: CALC_CHAIN_EN (enter in SHOW reloads the result as A via CHAIN).
// Ports: clock, reset_n (async active-low), key_enter, key_clear (raw async levels),
//        op_in (op switches), sel (command), op (latched op), busy (timed command active),
//        result_valid (in SHOW). All outputs registered and change with the state.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned LOAD_CYCLES = 4,
    parameter int unsigned EXEC_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             key_enter,
    input  logic             key_clear,
    input  logic [OP_W-1:0]  op_in,
    output logic [SEL_W-1:0] sel,
    output logic [OP_W-1:0]  op,
    output logic             busy,
    output logic             result_valid
);

    localparam int unsigned MAX_CYC = (LOAD_CYCLES > EXEC_CYCLES) ? LOAD_CYCLES : EXEC_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXEC_INIT = CNT_W'(EXEC_CYCLES - 1);

    logic enter_p;
    logic clear_p;

    calc_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0]  op_d;
    logic [SEL_W-1:0] sel_d;
    logic             busy_d;
    logic             result_valid_d;

    key_pulse u_enter (
        .clock   (clock),
        .reset_n (reset_n),
        .key     (key_enter),
        .pulse   (enter_p)
    );

    key_pulse u_clear (
        .clock   (clock),
        .reset_n (reset_n),
        .key     (key_clear),
        .pulse   (clear_p)
    );

    // State, dwell counter and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sel          <= SEL_IDLE;
            op           <= OP_ADD;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel          <= sel_d;
            op           <= op_d;
            busy         <= busy_d;
            result_valid <= result_valid_d;
        end
    end

    // Next state; outputs decoded from the next state so they move with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        op_d    = op;

        if (clear_p) begin
            // Clear beats everything, including a same-cycle enter.
            state_d = CLEAR;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (enter_p) begin
                    state_d = LOAD_A;
                    cnt_d   = LOAD_INIT;
                end
                LOAD_A: if (cnt_q == '0) state_d = WAIT_OP;
                WAIT_OP: if (enter_p) begin
                    state_d = LOAD_B;
                    cnt_d   = LOAD_INIT;
                    op_d    = op_in;
                end
                LOAD_B: if (cnt_q == '0) state_d = WAIT_EXEC;
                WAIT_EXEC: if (enter_p) begin
                    state_d = EXEC;
                    cnt_d   = EXEC_INIT;
                end
                EXEC: if (cnt_q == '0) state_d = SHOW;
                SHOW: if (enter_p) begin
`ifdef CALC_CHAIN_EN
                    state_d = CHAIN;
                    cnt_d   = LOAD_INIT;
`else
                    state_d = CLEAR;
                    cnt_d   = '0;
`endif
                end
                CLEAR: if (cnt_q == '0) state_d = IDLE;
`ifdef CALC_CHAIN_EN
                CHAIN: if (cnt_q == '0) state_d = WAIT_OP;
`endif
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (state_d == CLEAR) op_d = OP_ADD;

        sel_d          = sel_of(state_d);
        busy_d         = busy_of(state_d);
        result_valid_d = (state_d == SHOW);
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: full pass, held key, mid-load clear,
// simultaneous enter/clear, async reset mid-EXEC, and the SHOW exit for either build.
module tb_calc_sequencer;

    logic       clock;
    logic       reset_n;
    logic       key_enter;
    logic       key_clear;
    logic [1:0] op_in;
    logic [2:0] sel;
    logic [1:0] op;
    logic       busy;
    logic       result_valid;

    int checks = 0;
    int errors = 0;

    calc_sequencer #(.LOAD_CYCLES(4), .EXEC_CYCLES(2)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .key_enter    (key_enter),
        .key_clear    (key_clear),
        .op_in        (op_in),
        .sel          (sel),
        .op           (op),
        .busy         (busy),
        .result_valid (result_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Check sel holds exp for n consecutive cycles.
    task automatic run(input string tag, input logic [2:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, 8'(sel), 8'(exp));
            tick();
        end
    endtask

    // Press enter, let the entered state dwell, release with the key low for 2 cycles.
    task automatic enter_step(input int dwell);
        key_enter = 1'b1;
        repeat (4 + dwell) tick();
        key_enter = 1'b0;
        repeat (2) tick();
    endtask

    int  entries;
    int  load_cyc;
    bit  seen_exec;
    logic [2:0] prev_sel;

    initial begin
        reset_n   = 1'b0;
        key_enter = 1'b0;
        key_clear = 1'b0;
        op_in     = 2'b00;
        repeat (3) tick();

        // Reset values
        check("rst_sel", 8'(sel), 8'h0);
        check("rst_op", 8'(op), 8'h0);
        check("rst_busy", 8'(busy), 8'h0);
        check("rst_rv", 8'(result_valid), 8'h0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Full pass: A, op=10, B, exec, show; also pins key latency
        key_enter = 1'b1;
        repeat (3) tick();
        check("lat_pre", 8'(sel), 8'h0);
        tick();
        check("lat_busy", 8'(busy), 8'h1);
        run("load_a", 3'b001, 4);
        check("wait_op", 8'(sel), 8'h0);
        check("wait_op_busy", 8'(busy), 8'h0);
        key_enter = 1'b0;
        repeat (2) tick();
        op_in     = 2'b10;
        key_enter = 1'b1;
        repeat (4) tick();
        run("load_b", 3'b010, 4);
        check("wait_exec", 8'(sel), 8'h0);
        check("op_latched", 8'(op), 8'h2);
        key_enter = 1'b0;
        op_in     = 2'b00;
        repeat (2) tick();
        key_enter = 1'b1;
        repeat (4) tick();
        run("exec", 3'b011, 2);
        check("show_sel", 8'(sel), 8'h6);
        check("show_rv", 8'(result_valid), 8'h1);
        check("show_op", 8'(op), 8'h2);
        check("show_busy", 8'(busy), 8'h0);
        key_enter = 1'b0;
        repeat (2) tick();

        // Enter in SHOW
        key_enter = 1'b1;
        repeat (4) tick();
`ifdef CALC_CHAIN_EN
        run("chain", 3'b101, 4);
        check("chain_wait_op", 8'(sel), 8'h0);
        check("chain_op_kept", 8'(op), 8'h2);
        key_enter = 1'b0;
        key_clear = 1'b1;
        repeat (4) tick();
        check("chain_clr", 8'(sel), 8'h4);
        tick();
        check("chain_idle", 8'(sel), 8'h0);
        key_clear = 1'b0;
        repeat (2) tick();
`else
        check("show_clr", 8'(sel), 8'h4);
        check("show_clr_op", 8'(op), 8'h0);
        tick();
        check("show_idle", 8'(sel), 8'h0);
        check("show_idle_busy", 8'(busy), 8'h0);
        key_enter = 1'b0;
        repeat (2) tick();
`endif

        // Held enter: one LOAD_A entry of 4 cycles, then WAIT_OP
        entries   = 0;
        load_cyc  = 0;
        prev_sel  = sel;
        key_enter = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (sel == 3'b001 && prev_sel != 3'b001) entries++;
            if (sel == 3'b001) load_cyc++;
            prev_sel = sel;
        end
        check("held_entries", 8'(entries), 8'd1);
        check("held_load_cyc", 8'(load_cyc), 8'd4);
        check("held_end_sel", 8'(sel), 8'h0);
        key_enter = 1'b0;
        repeat (2) tick();

        // Enter from WAIT_OP (proves we were there), clear lands in cycle 2 of LOAD_B
        op_in     = 2'b01;
        key_enter = 1'b1;
        repeat (2) tick();
        key_clear = 1'b1;
        repeat (2) tick();
        check("lb_c1", 8'(sel), 8'h2);
        check("lb_op", 8'(op), 8'h1);
        tick();
        check("lb_c2", 8'(sel), 8'h2);
        tick();
        check("mid_clr", 8'(sel), 8'h4);
        check("mid_clr_busy", 8'(busy), 8'h1);
        check("mid_clr_op", 8'(op), 8'h0);
        tick();
        check("mid_idle", 8'(sel), 8'h0);
        check("mid_idle_busy", 8'(busy), 8'h0);
        check("mid_idle_op", 8'(op), 8'h0);
        key_enter = 1'b0;
        key_clear = 1'b0;
        op_in     = 2'b00;
        repeat (2) tick();

        // Simultaneous enter and clear in WAIT_EXEC
        enter_step(4);
        enter_step(4);
        key_enter = 1'b1;
        key_clear = 1'b1;
        repeat (4) tick();
        check("sim_clr", 8'(sel), 8'h4);
        seen_exec = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (sel == 3'b011) seen_exec = 1'b1;
        end
        check("sim_no_exec", 8'(seen_exec), 8'h0);
        check("sim_idle", 8'(sel), 8'h0);
        key_enter = 1'b0;
        key_clear = 1'b0;
        repeat (2) tick();

        // Async reset mid-EXEC
        op_in = 2'b11;
        enter_step(4);
        enter_step(4);
        key_enter = 1'b1;
        repeat (4) tick();
        check("pre_rst_exec", 8'(sel), 8'h3);
        check("pre_rst_op", 8'(op), 8'h3);
        #2 reset_n = 1'b0;
        #1;
        check("arst_sel", 8'(sel), 8'h0);
        check("arst_op", 8'(op), 8'h0);
        check("arst_busy", 8'(busy), 8'h0);
        check("arst_rv", 8'(result_valid), 8'h0);
        key_enter = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        check("post_rst_idle", 8'(sel), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
